instr_fetch: RTL and testbench

//  Front-end fetch stage: holds the PC and issues word reads to instruction memory over a req/gnt/rvalid interface.

---
 rtl/instr_fetch.sv | 261 ++++++++++++++++++++++++++
 tb/tb_instr_fetch.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//
// Front-end fetch stage. Holds the program counter and issues word reads to
// instruction memory over a req/gnt/rvalid interface. Returned words are
// tagged with their fetch PC and buffered in a small in-order FIFO whose head
// is presented to decode. A redirect (taken branch/jump) flushes the buffer,
// restarts fetch at the target and discards responses still in flight.
//
// Parameters
//   RESET_PC    first PC fetched after reset
//   FIFO_DEPTH  instruction buffer entries, also the outstanding-request
//               limit (power of 2, >= 2)
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   imem_req_o         fetch request valid
//   imem_addr_o        fetch byte address (word aligned)
//   imem_gnt_i         request accepted this cycle
//   imem_rvalid_i      read data valid, in request order
//   imem_rdata_i       returned instruction word
//   redirect_i         restart fetch at redirect_pc_i
//   redirect_pc_i      redirect target (low two bits ignored)
//   stall_i            decode not accepting this cycle
//   instr_valid_o      buffer head valid
//   instr_o            buffer head instruction
//   instr_pc_o         PC of instr_o
//   instr_op_o         instr_o[31:26]
//   instr_funct_o      instr_o[5:0]
// ----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic [5:0]  instr_op_o,
  output logic [5:0]  instr_funct_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [AW-1:0] PTR_ONE      = AW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE      = CW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO     = {CW{1'b0}};
  localparam logic [CW:0]   CREDIT_LIMIT = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_BOOT  = 2'b00,
    S_FETCH = 2'b01,
    S_FLUSH = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  // PC tags of requests in flight, popped in order as responses return
  logic [31:0]   tag_mem_q [FIFO_DEPTH];
  logic [AW-1:0] tag_wr_q, tag_wr_d;
  logic [AW-1:0] tag_rd_q, tag_rd_d;

  // Instruction buffer
  logic [31:0]   fifo_data_q [FIFO_DEPTH];
  logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
  logic [AW-1:0] fifo_wr_q, fifo_wr_d;
  logic [AW-1:0] fifo_rd_q, fifo_rd_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

  logic credit_ok_s;
  logic gnt_acc_s;
  logic rsp_s;
  logic drop_s;
  logic push_s;
  logic pop_s;

  // Buffer head is presented straight from the storage registers
  assign instr_valid_o = (fifo_cnt_q != CNT_ZERO);
  assign instr_o       = fifo_data_q[fifo_rd_q];
  assign instr_pc_o    = fifo_pc_q[fifo_rd_q];
  assign instr_op_o    = instr_o[31:26];
  assign instr_funct_o = instr_o[5:0];
  assign imem_addr_o   = pc_q;

  // Request issue and per-cycle event qualifiers
  always_comb begin
    // Buffered plus in-flight words may never exceed the buffer size, so
    // every response that is kept always has a free slot.
    credit_ok_s = (({1'b0, fifo_cnt_q} + {1'b0, out_cnt_q}) < CREDIT_LIMIT);
    imem_req_o  = (state_q == S_FETCH) && !redirect_i && credit_ok_s;
    gnt_acc_s   = imem_req_o && imem_gnt_i;
    // A response with nothing outstanding is a protocol error; ignore it
    rsp_s       = imem_rvalid_i && (out_cnt_q != CNT_ZERO);
    drop_s      = rsp_s && (drop_cnt_q != CNT_ZERO);
    push_s      = rsp_s && !redirect_i && (drop_cnt_q == CNT_ZERO);
    pop_s       = instr_valid_o && !stall_i && !redirect_i;
  end

  // PC, outstanding-request and stale-response counters
  always_comb begin
    pc_d       = pc_q;
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;

    if (redirect_i) begin
      pc_d = redirect_pc_i & 32'hFFFF_FFFC;
    end else if (gnt_acc_s) begin
      pc_d = pc_q + 32'h0000_0004;
    end else begin
      pc_d = pc_q;
    end

    if (gnt_acc_s && !rsp_s) begin
      out_cnt_d = out_cnt_q + CNT_ONE;
    end else if (!gnt_acc_s && rsp_s) begin
      out_cnt_d = out_cnt_q - CNT_ONE;
    end else begin
      out_cnt_d = out_cnt_q;
    end

    // Everything still in flight after a redirect belongs to the old path
    if (redirect_i) begin
      drop_cnt_d = out_cnt_d;
    end else if (drop_s) begin
      drop_cnt_d = drop_cnt_q - CNT_ONE;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end

    if (gnt_acc_s) begin
      tag_wr_d = tag_wr_q + PTR_ONE;
    end else begin
      tag_wr_d = tag_wr_q;
    end

    // Tags are consumed for dropped responses too, keeping the queue aligned
    if (rsp_s) begin
      tag_rd_d = tag_rd_q + PTR_ONE;
    end else begin
      tag_rd_d = tag_rd_q;
    end
  end

  // Instruction buffer pointers and occupancy
  always_comb begin
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_cnt_d = fifo_cnt_q;

    if (redirect_i) begin
      // Flush: the write pointer snaps back to the read pointer
      fifo_wr_d  = fifo_rd_q;
      fifo_rd_d  = fifo_rd_q;
      fifo_cnt_d = CNT_ZERO;
    end else begin
      if (push_s) begin
        fifo_wr_d = fifo_wr_q + PTR_ONE;
      end else begin
        fifo_wr_d = fifo_wr_q;
      end

      if (pop_s) begin
        fifo_rd_d = fifo_rd_q + PTR_ONE;
      end else begin
        fifo_rd_d = fifo_rd_q;
      end

      case ({push_s, pop_s})
        2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_ONE;
        2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_ONE;
        default: fifo_cnt_d = fifo_cnt_q;
      endcase
    end
  end

  // Fetch FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (redirect_i && (drop_cnt_d != CNT_ZERO)) begin
          state_d = S_FLUSH;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_FLUSH: begin
        // drop_cnt_d already reflects a re-redirect inside FLUSH
        if (drop_cnt_d == CNT_ZERO) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_FLUSH;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      out_cnt_q  <= CNT_ZERO;
      drop_cnt_q <= CNT_ZERO;
      tag_wr_q   <= {AW{1'b0}};
      tag_rd_q   <= {AW{1'b0}};
      fifo_wr_q  <= {AW{1'b0}};
      fifo_rd_q  <= {AW{1'b0}};
      fifo_cnt_q <= CNT_ZERO;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Tag and instruction storage; reset so the idle head reads 0 / RESET_PC
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_mem_q   <= '{default: RESET_PC};
      fifo_data_q <= '{default: 32'h0000_0000};
      fifo_pc_q   <= '{default: RESET_PC};
    end else begin
      if (gnt_acc_s) begin
        tag_mem_q[tag_wr_q] <= pc_q;
      end
      if (push_s) begin
        fifo_data_q[fifo_wr_q] <= imem_rdata_i;
        fifo_pc_q[fifo_wr_q]   <= tag_mem_q[tag_rd_q];
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, reset_b, sel;
  logic        gnt, rvalid, redirect, stall;
  logic [31:0] rdata, redirect_pc;

  logic        req_a, req_b, valid_a, valid_b;
  logic [31:0] addr_a, addr_b, instr_a, instr_b, ipc_a, ipc_b;
  logic [5:0]  op_a, op_b, funct_a, funct_b;

  logic        req_s, valid_s;
  logic [31:0] addr_s, instr_s, ipc_s;
  logic [5:0]  op_s, funct_s;

  instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) u_dut_a (
    .clk(clk), .reset(reset_a),
    .imem_req_o(req_a), .imem_addr_o(addr_a), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .stall_i(stall),
    .instr_valid_o(valid_a), .instr_o(instr_a), .instr_pc_o(ipc_a),
    .instr_op_o(op_a), .instr_funct_o(funct_a)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) u_dut_b (
    .clk(clk), .reset(reset_b),
    .imem_req_o(req_b), .imem_addr_o(addr_b), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .stall_i(stall),
    .instr_valid_o(valid_b), .instr_o(instr_b), .instr_pc_o(ipc_b),
    .instr_op_o(op_b), .instr_funct_o(funct_b)
  );

  // The instance out of reset is the one being observed
  assign req_s   = sel ? req_b   : req_a;
  assign addr_s  = sel ? addr_b  : addr_a;
  assign valid_s = sel ? valid_b : valid_a;
  assign instr_s = sel ? instr_b : instr_a;
  assign ipc_s   = sel ? ipc_b   : ipc_a;
  assign op_s    = sel ? op_b    : op_a;
  assign funct_s = sel ? funct_b : funct_a;

  typedef struct packed {
    logic [31:0] addr;
    logic        stale;
  } pend_t;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } exp_t;

  pend_t       pend_q[$];   // requests granted, response not yet returned
  exp_t        exp_q[$];    // scoreboard: words the DUT buffer must present
  logic [31:0] exp_pc;
  bit          booted, gnt_en, rsp_en, stray;
  int          n_checks, n_fail;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic bit any_stale();
    bit s;
    s = 1'b0;
    foreach (pend_q[i]) if (pend_q[i].stale) s = 1'b1;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hold both DUTs in reset, check reset outputs of `which`, release it.
  task automatic do_reset(input bit which);
    @(negedge clk);
    sel = which; reset_a = 1'b1; reset_b = 1'b1;
    redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   req_s,   32'h0);
    chk("rst_valid", valid_s, 32'h0);
    chk("rst_instr", instr_s, 32'h0);
    chk("rst_op",    op_s,    32'h0);
    chk("rst_funct", funct_s, 32'h0);
    chk("rst_ipc",   ipc_s,   which ? 32'hFFFF_FFF8 : 32'h0);
    chk("rst_addr",  addr_s,  which ? 32'hFFFF_FFF8 : 32'h0);
    if (which) reset_b = 1'b0; else reset_a = 1'b0;
    pend_q.delete();
    exp_q.delete();
    exp_pc = which ? 32'hFFFF_FFF8 : 32'h0;
    booted = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare outputs, advance the model.
  task automatic cycle(input bit redir, input logic [31:0] rpc, input bit stl);
    pend_t p;
    exp_t  e;
    bit    exp_req;
    @(negedge clk);
    redirect = redir; redirect_pc = rpc; stall = stl; gnt = gnt_en;
    if (stray) begin
      rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    end else if (rsp_en && pend_q.size() != 0) begin
      rvalid = 1'b1; rdata = word_of(pend_q[0].addr);
    end else begin
      rvalid = 1'b0; rdata = 32'h0;
    end
    #1;
    chk("valid", valid_s, (exp_q.size() != 0) ? 32'h1 : 32'h0);
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      chk("instr", instr_s, e.word);
      chk("ipc",   ipc_s,   e.pc);
      chk("op",    op_s,    {26'h0, e.word[31:26]});
      chk("funct", funct_s, {26'h0, e.word[5:0]});
    end
    exp_req = booted && !redir && !any_stale() && ((exp_q.size() + pend_q.size()) < DEPTH);
    chk("req", req_s, exp_req ? 32'h1 : 32'h0);
    if (exp_req) chk("addr", addr_s, exp_pc);
    // model update for the coming edge
    if (exp_q.size() != 0 && !stl && !redir) void'(exp_q.pop_front());
    if (rvalid && !stray) begin
      p = pend_q.pop_front();
      if (!p.stale && !redir) begin
        e.word = word_of(p.addr);
        e.pc   = p.addr;
        exp_q.push_back(e);
      end
    end
    if (exp_req && gnt_en) begin
      p.addr = exp_pc; p.stale = 1'b0;
      pend_q.push_back(p);
      exp_pc = exp_pc + 32'h4;
    end
    if (redir) begin
      exp_q.delete();
      foreach (pend_q[i]) pend_q[i].stale = 1'b1;
      exp_pc = rpc & 32'hFFFF_FFFC;
    end
    booted = 1'b1;
    stray  = 1'b0;
  endtask

  initial begin
    int n;
    reset_a = 1'b1; reset_b = 1'b1; sel = 1'b0;
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    gnt_en = 1'b1; rsp_en = 1'b1; stray = 1'b0;
    n_checks = 0; n_fail = 0;
    exp_pc = 32'h0; booted = 1'b0;

    // sequential fetch from address 0
    do_reset(1'b0);
    repeat (12) cycle(1'b0, 32'h0, 1'b0);

    // decode stall fills the buffer, then release
    repeat (6) cycle(1'b0, 32'h0, 1'b1);
    repeat (6) cycle(1'b0, 32'h0, 1'b0);

    // memory withholds grant
    gnt_en = 1'b0; repeat (3) cycle(1'b0, 32'h0, 1'b0);
    gnt_en = 1'b1; repeat (4) cycle(1'b0, 32'h0, 1'b0);

    // redirect with two requests outstanding
    rsp_en = 1'b0; repeat (4) cycle(1'b0, 32'h0, 1'b0);
    chk("two_outstanding", pend_q.size(), 32'h2);
    cycle(1'b1, 32'h0000_0100, 1'b0);
    rsp_en = 1'b1; repeat (8) cycle(1'b0, 32'h0, 1'b0);

    // second redirect while still flushing
    rsp_en = 1'b0; repeat (4) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h0000_0200, 1'b0);
    rsp_en = 1'b1;
    cycle(1'b1, 32'h0000_0300, 1'b1);
    repeat (8) cycle(1'b0, 32'h0, 1'b0);

    // redirect coincident with an rvalid and a buffer pop
    n = 0;
    while (!(exp_q.size() != 0 && pend_q.size() != 0) && n < 10) begin
      cycle(1'b0, 32'h0, 1'b0);
      n++;
    end
    chk("coincide_setup", (n < 10) ? 32'h1 : 32'h0, 32'h1);
    cycle(1'b1, 32'h0000_0400, 1'b0);
    repeat (6) cycle(1'b0, 32'h0, 1'b0);

    // reset with a request outstanding; its response arrives after reset
    rsp_en = 1'b0;
    do_reset(1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    chk("one_outstanding", pend_q.size(), 32'h1);
    do_reset(1'b0);
    rsp_en = 1'b1;
    cycle(1'b0, 32'h0, 1'b0);
    stray = 1'b1;
    cycle(1'b0, 32'h0, 1'b0);
    repeat (6) cycle(1'b0, 32'h0, 1'b0);

    // PC wrap from RESET_PC = FFFF_FFF8, then unaligned redirect target
    do_reset(1'b1);
    repeat (8) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h0000_0103, 1'b0);
    repeat (6) cycle(1'b0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
